mem_controller: RTL
===================

MEM_CONTROLLER -- requirements
Module: mem_controller

Interface
REQ-001 Parameter WAIT_STATES, default 2: extra SRAM cycles per access beyond the first; legal range 1..7.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 mem_read  in  1  CPU data-read request, level.
REQ-005 mem_write  in  1  CPU data-write request, level; write data on d_bus.
REQ-006 d_addr  in  16  CPU data address.
REQ-007 i_addr  in  16  CPU instruction address.
REQ-008 i_bus  out  16  registered instruction word for the last completed fetch.
REQ-009 d_bus  inout  16  driven by this block only per REQ-021; otherwise high-Z.
REQ-010 stall  out  1  combinational; high while any CPU request is unserved.
REQ-011 sram_addr  out  16  external SRAM address, registered.
REQ-012 sram_data  inout  16  external SRAM data; driven only during write access.
REQ-013 sram_ce_n, sram_oe_n, sram_we_n  out  1 each  active-low SRAM strobes, registered.

Function
REQ-014 States: IDLE, ACCESS; a cycle counter runs 0..WAIT_STATES in ACCESS.
REQ-015 Data request = (mem_read|mem_write) and not (data_done with unchanged d_addr and op); fetch request = !fetch_valid or i_addr != fetched_addr.
REQ-016 In IDLE, a data request has priority over a fetch request; the chosen address, op and write data are latched on the entry edge into ACCESS.
REQ-017 mem_read and mem_write both high is a write; d_bus is not driven.
REQ-018 ACCESS lasts exactly WAIT_STATES+1 cycles; sram_ce_n low throughout; sram_oe_n low throughout reads; sram_we_n low on counts 0..WAIT_STATES-1, high on the final count, with sram_data held through the final count.
REQ-019 Final read cycle: sram_data captured into i_bus (fetch: fetch_valid=1, fetched_addr=latched address) or into the data-read register (data_done=1); state returns to IDLE.
REQ-020 Final write cycle: data_done=1; state returns to IDLE.
REQ-021 d_bus = data-read register when mem_read & !mem_write & data_done; else high-Z.
REQ-022 data_done clears when mem_read and mem_write are both low, or when d_addr/op differs from the latched value; the latter triggers a new access (back-to-back accesses with no idle gap beyond one IDLE cycle).
REQ-023 stall = data request pending | fetch request pending; stall is low in the same cycle data_done and fetch_valid both satisfy the current CPU inputs.
REQ-024 Minimum request-to-stall-low latency: WAIT_STATES+2 cycles (one IDLE cycle, WAIT_STATES+1 ACCESS cycles).
REQ-025 Changes of i_addr or d_addr during ACCESS do not disturb the access in progress; they are re-evaluated in the next IDLE cycle.
REQ-026 Address arithmetic: none; addresses pass through unmodified, no wrap logic.

Reset
REQ-027 On rst: state=IDLE, counter=0, fetch_valid=0, data_done=0, i_bus=0, data-read register=0, sram_addr=0, all strobes high, sram_data and d_bus high-Z.
REQ-028 rst asserted mid-ACCESS aborts the access in the same edge; no partial write completes (sram_we_n high after that edge).
REQ-029 After rst release stall=1 until the first fetch completes.

Structure
REQ-030 Shared package mem_pkg holds the state enum, ADDR_W=16, DATA_W=16, and the WAIT_STATES default.
REQ-031 Single module; no sub-module is required.

Verification
REQ-032 Reset release, i_addr=0x0000, SRAM[0]=0x1234 -> stall high 4 cycles (WAIT_STATES=2), then i_bus=0x1234, stall=0.
REQ-033 mem_read, d_addr=0x0040, SRAM[0x40]=0xBEEF, fetch also pending -> data access first, d_bus=0xBEEF, then fetch; stall low only after both complete.
REQ-034 mem_write, d_addr=0x0010, d_bus=0x00A5 -> sram_we_n low exactly 2 cycles, SRAM[0x10]=0x00A5, stall low on cycle 4.
REQ-035 mem_read held, d_addr 0x0020->0x0021 after completion -> second access starts, d_bus updates to SRAM[0x21].
REQ-036 rst asserted on ACCESS count 1 of a write to 0x0030 -> SRAM[0x30] unchanged, strobes high next cycle, i_bus=0.
REQ-037 mem_read and mem_write both high -> write performed, d_bus never driven by block.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg
// Shared definitions for the SRAM memory controller: bus widths, the
// default number of SRAM wait states, the access counter width and the
// controller state encoding.
// No ports (package).
package mem_pkg;

    localparam int ADDR_W              = 16;
    localparam int DATA_W              = 16;
    localparam int DEFAULT_WAIT_STATES = 2;

    // Wide enough for the largest legal wait-state count (7).
    localparam int COUNT_W = 3;

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

endpackage

// File: rtl/mem_controller_if.sv
// mem_controller_if
// CPU-side bus of the memory controller.
// Ports (signals):
//   mem_read, mem_write  CPU data request levels
//   d_addr               CPU data address
//   i_addr               CPU instruction address
//   i_bus                instruction word from the last completed fetch
//   stall                high while any CPU request is unserved
// Modports: master = CPU, slave = controller.
interface mem_controller_if;
    import mem_pkg::*;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] d_addr;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_bus;
    logic              stall;

    modport master (
        output mem_read, mem_write, d_addr, i_addr,
        input  i_bus, stall
    );

    modport slave (
        input  mem_read, mem_write, d_addr, i_addr,
        output i_bus, stall
    );

endinterface

// File: rtl/mem_controller.sv
// mem_controller
// Arbitrates CPU data accesses and instruction fetches onto a single
// asynchronous SRAM. Each SRAM access takes WAIT_STATES+1 cycles; data
// requests win over fetches when both are pending in IDLE.
// Ports:
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset
//   cpu        CPU bus (mem_controller_if.slave)
//   d_bus      CPU data bus; driven with read data only when a read is done
//   sram_addr  registered SRAM address
//   sram_data  SRAM data; driven by this block only during write accesses
//   sram_ce_n, sram_oe_n, sram_we_n  registered active-low SRAM strobes
module mem_controller
    import mem_pkg::*;
#(
    parameter int WAIT_STATES = DEFAULT_WAIT_STATES
) (
    input  logic              clk,
    input  logic              rst,
    mem_controller_if.slave   cpu,
    inout  wire  [DATA_W-1:0] d_bus,
    output logic [ADDR_W-1:0] sram_addr,
    inout  wire  [DATA_W-1:0] sram_data,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n
);

    localparam logic [COUNT_W-1:0] LAST_COUNT = COUNT_W'(WAIT_STATES);

    state_t             state;
    logic [COUNT_W-1:0] count;
    logic [COUNT_W-1:0] count_next;

    logic               acc_fetch;
    logic               acc_write;
    logic [DATA_W-1:0]  wdata;

    logic               fetch_valid;
    logic [ADDR_W-1:0]  fetched_addr;
    logic [DATA_W-1:0]  i_bus_q;

    logic               data_done;
    logic [ADDR_W-1:0]  done_addr;
    logic               done_write;
    logic [DATA_W-1:0]  dread;

    logic               data_match;
    logic               data_req;
    logic               fetch_req;

    // A completed data access keeps satisfying the CPU only while it presents
    // the same address and operation (write wins when both levels are high).
    always_comb begin
        data_match = 1'b0;
        data_req   = 1'b0;
        fetch_req  = 1'b0;
        data_match = (cpu.d_addr == done_addr) && (cpu.mem_write == done_write);
        data_req   = (cpu.mem_read || cpu.mem_write) && !(data_done && data_match);
        fetch_req  = !fetch_valid || (cpu.i_addr != fetched_addr);
    end

    assign count_next = count + 1'b1;

    assign cpu.stall  = data_req || fetch_req;
    assign cpu.i_bus  = i_bus_q;

    assign d_bus     = (cpu.mem_read && !cpu.mem_write && data_done) ? dread : 'z;
    assign sram_data = (state == ACCESS && acc_write) ? wdata : 'z;

    // Single FSM: IDLE picks the next request and latches address, op and
    // write data on the entry edge; ACCESS counts 0..WAIT_STATES and
    // completes on the final count. The write strobe is released one cycle
    // before the end so the SRAM commits while data is still being driven.
    // Reset drops all strobes in the same edge, so an interrupted write never
    // sees a we_n rising edge with ce_n low.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            count        <= '0;
            acc_fetch    <= 1'b0;
            acc_write    <= 1'b0;
            wdata        <= '0;
            fetch_valid  <= 1'b0;
            fetched_addr <= '0;
            i_bus_q      <= '0;
            data_done    <= 1'b0;
            done_addr    <= '0;
            done_write   <= 1'b0;
            dread        <= '0;
            sram_addr    <= '0;
            sram_ce_n    <= 1'b1;
            sram_oe_n    <= 1'b1;
            sram_we_n    <= 1'b1;
        end else begin
            if ((!cpu.mem_read && !cpu.mem_write) || !data_match) begin
                data_done <= 1'b0;
            end

            case (state)
                IDLE: begin
                    count <= '0;
                    if (data_req) begin
                        state      <= ACCESS;
                        acc_fetch  <= 1'b0;
                        acc_write  <= cpu.mem_write;
                        wdata      <= d_bus;
                        sram_addr  <= cpu.d_addr;
                        done_addr  <= cpu.d_addr;
                        done_write <= cpu.mem_write;
                        data_done  <= 1'b0;
                        sram_ce_n  <= 1'b0;
                        sram_oe_n  <= cpu.mem_write;
                        sram_we_n  <= !cpu.mem_write;
                    end else if (fetch_req) begin
                        state      <= ACCESS;
                        acc_fetch  <= 1'b1;
                        acc_write  <= 1'b0;
                        sram_addr  <= cpu.i_addr;
                        sram_ce_n  <= 1'b0;
                        sram_oe_n  <= 1'b0;
                        sram_we_n  <= 1'b1;
                    end
                end

                ACCESS: begin
                    if (count == LAST_COUNT) begin
                        state     <= IDLE;
                        count     <= '0;
                        sram_ce_n <= 1'b1;
                        sram_oe_n <= 1'b1;
                        sram_we_n <= 1'b1;
                        if (acc_fetch) begin
                            i_bus_q      <= sram_data;
                            fetch_valid  <= 1'b1;
                            fetched_addr <= sram_addr;
                        end else begin
                            if (!acc_write) begin
                                dread <= sram_data;
                            end
                            data_done <= 1'b1;
                        end
                    end else begin
                        count <= count_next;
                        if (count_next == LAST_COUNT) begin
                            sram_we_n <= 1'b1;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
